// File: rtl/perceptron_weight_bank.sv
// perceptron_weight_bank
//   Perceptron weight store for the branch-prediction stage. NUM_PORTS parallel
//   registered reads (latency 1) and a read-modify-write trainer that updates one
//   entry every 3 cycles with saturating bias/history weights.
//   Optional build macro WT_BYPASS_EN: a read accepted in T_WRITE that targets the
//   entry being trained returns the updated entry instead of the pre-update one.
module perceptron_weight_bank #(
    parameter int NUM_PORTS = 4,
    parameter int HIST_LEN  = 8,
    parameter int W_WIDTH   = 8,
    parameter int ADDR_W    = 8,
    localparam int ENTRY_W  = (HIST_LEN + 1) * W_WIDTH
) (
    input  logic                          i_fire,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          i_rd_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]   i_rd_addr,
    output logic                          o_rd_ready,
    output logic [NUM_PORTS-1:0]          o_rd_valid,
    output logic [NUM_PORTS*ENTRY_W-1:0]  o_weights,
    input  logic                          i_train_valid,
    input  logic [ADDR_W-1:0]             i_train_addr,
    input  logic [HIST_LEN-1:0]           i_train_hist,
    input  logic                          i_train_taken,
    output logic                          o_train_ready,
    output logic                          o_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic signed [W_WIDTH:0] W_MAX   = {2'b00, {(W_WIDTH-1){1'b1}}};
    localparam logic signed [W_WIDTH:0] W_MIN   = {2'b11, {(W_WIDTH-1){1'b0}}};
    localparam logic signed [W_WIDTH:0] STEP_UP = {{W_WIDTH{1'b0}}, 1'b1};
    localparam logic signed [W_WIDTH:0] STEP_DN = '1;

    typedef enum logic [1:0] {IDLE, T_READ, T_WRITE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]   stg_addr;
    logic [HIST_LEN-1:0] stg_hist;
    logic                stg_taken;
    logic [ENTRY_W-1:0]  stg_entry;
    logic [ENTRY_W-1:0]  upd_entry;
    logic [ENTRY_W-1:0]  rd_data [NUM_PORTS];
    logic                train_accept;

    // One saturating +/-1 step on a signed weight, computed one bit wider then clamped
    function automatic logic [W_WIDTH-1:0] sat_step(input logic [W_WIDTH-1:0] w,
                                                    input logic up);
        logic signed [W_WIDTH:0] sum;
        sum = $signed({w[W_WIDTH-1], w}) + (up ? STEP_UP : STEP_DN);
        if (sum > W_MAX) begin
            return W_MAX[W_WIDTH-1:0];
        end else if (sum < W_MIN) begin
            return W_MIN[W_WIDTH-1:0];
        end
        return sum[W_WIDTH-1:0];
    endfunction

    assign train_accept = i_train_valid & o_train_ready;

    // Trainer state register
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Trainer next-state: IDLE -> T_READ -> T_WRITE -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (train_accept) state_nxt = T_READ;
            T_READ:  state_nxt = T_WRITE;
            T_WRITE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Trainer outputs: read port is stolen only during T_READ
    always_comb begin
        o_rd_ready    = 1'b1;
        o_train_ready = 1'b0;
        o_busy        = 1'b1;
        case (state)
            IDLE: begin
                o_train_ready = 1'b1;
                o_busy        = 1'b0;
            end
            T_READ:  o_rd_ready = 1'b0;
            default: ;
        endcase
    end

    // Staging: capture the request on accept, latch the stored entry in T_READ
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            stg_addr  <= '0;
            stg_hist  <= '0;
            stg_taken <= 1'b0;
            stg_entry <= '0;
        end else begin
            if (train_accept) begin
                stg_addr  <= i_train_addr;
                stg_hist  <= i_train_hist;
                stg_taken <= i_train_taken;
            end
            if (state == T_READ) begin
                stg_entry <= mem[stg_addr];
            end
        end
    end

    // Updated entry: bias follows the outcome, history weight k agrees/disagrees with hist[k-1]
    always_comb begin
        upd_entry = '0;
        upd_entry[W_WIDTH-1:0] = sat_step(stg_entry[W_WIDTH-1:0], stg_taken);
        for (int unsigned k = 1; k <= HIST_LEN; k++) begin
            upd_entry[k*W_WIDTH +: W_WIDTH] =
                sat_step(stg_entry[k*W_WIDTH +: W_WIDTH], stg_hist[k-1] ~^ stg_taken);
        end
    end

    // Weight array: cleared by reset, written on the edge leaving T_WRITE
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (state == T_WRITE) begin
            mem[stg_addr] <= upd_entry;
        end
    end

    // Per-port read mux, with optional forwarding of the entry being written
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rd_data[p] = mem[i_rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef WT_BYPASS_EN
            if ((state == T_WRITE) && (i_rd_addr[p*ADDR_W +: ADDR_W] == stg_addr)) begin
                rd_data[p] = upd_entry;
            end
`endif
        end
    end

    // Registered read outputs; idle ports hold their last weights
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            o_weights  <= '0;
            o_rd_valid <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (o_rd_ready && i_rd_valid[p]) begin
                    o_weights[p*ENTRY_W +: ENTRY_W] <= rd_data[p];
                    o_rd_valid[p]                   <= 1'b1;
                end else begin
                    o_rd_valid[p] <= 1'b0;
                end
            end
        end
    end

endmodule
